package_header_parser: RTL and testbench

//  Upstream of the header checker. Parses the 16-bit word stream from the ADC link into packages.

---
 rtl/hdr_defs.sv | 35 +++
 rtl/pkg_timeout_ctr.sv | 42 ++++
 rtl/package_header_parser.sv | 142 ++++++++++++++
 tb/tb_package_header_parser.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdr_defs.sv
// ----------------------------------------------------------------------------
// hdr_defs
// Shared definitions for the package header parser slice: link word widths,
// default start/trailer markers and the parser FSM state encoding.
// ----------------------------------------------------------------------------
package hdr_defs;

  localparam int WORD_W    = 16;
  localparam int EVTNO_W   = 14;
  localparam int SPILLNO_W = 9;
  localparam int IDX_W     = 10;
  localparam int PKGCNT_W  = 16;

  localparam logic [WORD_W-1:0] DEF_START_WORD = 16'hBCBC;
  localparam logic [WORD_W-1:0] DEF_END_WORD   = 16'hFCFC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVT,
    ST_SPILL,
    ST_PAYLOAD,
    ST_TRAILER
  } parser_state_t;

  // The event word carries 14 bits of event number; the top two bits must be 0.
  function automatic logic evt_pad_ok(input logic [WORD_W-1:0] w);
    return (w[WORD_W-1:EVTNO_W] == '0);
  endfunction

  // The spill word carries 9 bits of spill number; the top seven bits must be 0.
  function automatic logic spill_pad_ok(input logic [WORD_W-1:0] w);
    return (w[WORD_W-1:SPILLNO_W] == '0);
  endfunction

endpackage

// File: rtl/pkg_timeout_ctr.sv
// ----------------------------------------------------------------------------
// pkg_timeout_ctr
// Counts consecutive idle cycles while a package is in flight and flags the
// cycle on which the TIMEOUT-th idle cycle occurs.
// Ports:
//   clk      system clock
//   rstn     synchronous reset, active-low
//   clear    restart the count (valid word, idle state, abort)
//   inc      this cycle is an idle cycle inside a package
//   expired  combinational: this idle cycle is the TIMEOUT-th in a row
// ----------------------------------------------------------------------------
module pkg_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // The count holds the number of idle cycles already seen, so the current
  // idle cycle is the TIMEOUT-th one when the count equals TIMEOUT-1.
  assign expired = inc && (count == LAST);

  // Clear wins over increment so the cycle that expires also restarts the count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/package_header_parser.sv
// ----------------------------------------------------------------------------
// package_header_parser
// Parses the 16-bit ADC link word stream into packages:
//   START_WORD, {2'b00,evtno}, {7'b0,spillno}, PAYLOAD_LEN payload words, END_WORD.
// Forwards payload words with their index, publishes evtno/spillno of each
// completed package with a get_package pulse, and flags format errors, bad
// trailers and idle timeouts with a frame_err pulse.
// Ports:
//   clk, rstn       clock, synchronous active-low reset
//   live_rising     start of live window; aborts package, clears pkg_count
//   data_in/valid   link word and its qualifier
//   pkg_evtno/spillno  numbers of the last completed package (held)
//   get_package     1-cycle pulse, package complete
//   payload_data/valid/idx  forwarded payload word, 0-based index
//   frame_err       1-cycle pulse, format error / bad trailer / timeout
//   pkg_count       completed packages since live_rising (wrapping)
// ----------------------------------------------------------------------------
module package_header_parser
  import hdr_defs::*;
#(
  parameter int                PAYLOAD_LEN = 64,
  parameter logic [WORD_W-1:0] START_WORD  = DEF_START_WORD,
  parameter logic [WORD_W-1:0] END_WORD    = DEF_END_WORD,
  parameter int                TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 live_rising,
  input  logic [WORD_W-1:0]    data_in,
  input  logic                 data_valid,
  output logic [EVTNO_W-1:0]   pkg_evtno,
  output logic [SPILLNO_W-1:0] pkg_spillno,
  output logic                 get_package,
  output logic [WORD_W-1:0]    payload_data,
  output logic                 payload_valid,
  output logic [IDX_W-1:0]     payload_idx,
  output logic                 frame_err,
  output logic [PKGCNT_W-1:0]  pkg_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);

  parser_state_t        state;
  logic [EVTNO_W-1:0]   evt_shadow;
  logic [SPILLNO_W-1:0] spill_shadow;
  logic [IDX_W-1:0]     payload_cnt;
  logic                 tmo_inc;
  logic                 tmo_clear;
  logic                 tmo_expired;

  // Idle cycles only count while a package is open; an abort by live_rising
  // takes precedence, so it must not also register as an idle cycle.
  assign tmo_inc   = (state != ST_IDLE) && !data_valid && !live_rising;
  assign tmo_clear = live_rising || data_valid || (state == ST_IDLE) || tmo_expired;

  pkg_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (tmo_clear),
    .inc     (tmo_inc),
    .expired (tmo_expired)
  );

  // Parser FSM with registered outputs. Pulses default low each cycle; the
  // priority is live_rising, then timeout, then the valid word. Event/spill
  // numbers are staged in shadow registers and only published on a good
  // trailer, so a broken package never disturbs pkg_evtno/pkg_spillno.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      evt_shadow    <= '0;
      spill_shadow  <= '0;
      payload_cnt   <= '0;
      pkg_evtno     <= '0;
      pkg_spillno   <= '0;
      get_package   <= 1'b0;
      payload_data  <= '0;
      payload_valid <= 1'b0;
      payload_idx   <= '0;
      frame_err     <= 1'b0;
      pkg_count     <= '0;
    end else begin
      get_package   <= 1'b0;
      frame_err     <= 1'b0;
      payload_valid <= 1'b0;
      if (live_rising) begin
        state     <= ST_IDLE;
        pkg_count <= '0;
      end else if (tmo_expired) begin
        frame_err <= 1'b1;
        state     <= ST_IDLE;
      end else if (data_valid) begin
        case (state)
          ST_IDLE: begin
            if (data_in == START_WORD) state <= ST_EVT;
          end
          ST_EVT: begin
            if (evt_pad_ok(data_in)) begin
              evt_shadow <= data_in[EVTNO_W-1:0];
              state      <= ST_SPILL;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          ST_SPILL: begin
            if (spill_pad_ok(data_in)) begin
              spill_shadow <= data_in[SPILLNO_W-1:0];
              payload_cnt  <= '0;
              state        <= ST_PAYLOAD;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          ST_PAYLOAD: begin
            payload_data  <= data_in;
            payload_valid <= 1'b1;
            payload_idx   <= payload_cnt;
            payload_cnt   <= payload_cnt + 1'b1;
            if (payload_cnt == LAST_IDX) state <= ST_TRAILER;
          end
          ST_TRAILER: begin
            if (data_in == END_WORD) begin
              pkg_evtno   <= evt_shadow;
              pkg_spillno <= spill_shadow;
              get_package <= 1'b1;
              pkg_count   <= pkg_count + 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_package_header_parser.sv
// ----------------------------------------------------------------------------
// tb_package_header_parser
// Directed, table-driven bench for package_header_parser with PAYLOAD_LEN=4
// and TIMEOUT=8, plus hand-written sequences for gaps, timeout, live_rising
// and mid-package reset.
// ----------------------------------------------------------------------------
module tb_package_header_parser;

  localparam int PLEN = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        live_rising;
  logic [15:0] data_in;
  logic        data_valid;
  logic [13:0] pkg_evtno;
  logic [8:0]  pkg_spillno;
  logic        get_package;
  logic [15:0] payload_data;
  logic        payload_valid;
  logic [9:0]  payload_idx;
  logic        frame_err;
  logic [15:0] pkg_count;

  int total_checks  = 0;
  int passed_checks = 0;

  typedef struct {
    logic [15:0] data;
    logic        exp_gp;
    logic        exp_fe;
    logic        exp_pv;
    logic [9:0]  exp_idx;
    logic [13:0] exp_evt;
    logic [8:0]  exp_spill;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  package_header_parser #(
    .PAYLOAD_LEN (PLEN),
    .START_WORD  (16'hBCBC),
    .END_WORD    (16'hFCFC),
    .TIMEOUT     (TMO)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .live_rising   (live_rising),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .pkg_evtno     (pkg_evtno),
    .pkg_spillno   (pkg_spillno),
    .get_package   (get_package),
    .payload_data  (payload_data),
    .payload_valid (payload_valid),
    .payload_idx   (payload_idx),
    .frame_err     (frame_err),
    .pkg_count     (pkg_count)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs (we sit #1 after a rising edge), then advance to
  // #1 after the next rising edge so the registered response is visible.
  task automatic applyStimulus(input logic rst_n, input logic live,
                               input logic valid, input logic [15:0] data);
    rstn        = rst_n;
    live_rising = live;
    data_valid  = valid;
    data_in     = data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual === expected) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic addRow(input logic [15:0] d, input logic gp, input logic fe,
                        input logic pv, input logic [9:0] idx, input logic [13:0] evt,
                        input logic [8:0] spill, input logic [15:0] cnt);
    vec_t v;
    v.data = d; v.exp_gp = gp; v.exp_fe = fe; v.exp_pv = pv; v.exp_idx = idx;
    v.exp_evt = evt; v.exp_spill = spill; v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  // Push a clean package with no gaps into the vector table.
  task automatic addCleanPkg(input logic [13:0] evt, input logic [8:0] spill,
                             input logic [15:0] base, input logic [13:0] prev_evt,
                             input logic [8:0] prev_spill, input logic [15:0] prev_cnt);
    addRow(16'hBCBC, 0, 0, 0, 0, prev_evt, prev_spill, prev_cnt);
    addRow({2'b00, evt}, 0, 0, 0, 0, prev_evt, prev_spill, prev_cnt);
    addRow({7'b0, spill}, 0, 0, 0, 0, prev_evt, prev_spill, prev_cnt);
    for (int i = 0; i < PLEN; i++)
      addRow(base + 16'(i), 0, 0, 1, 10'(i), prev_evt, prev_spill, prev_cnt);
    addRow(16'hFCFC, 1, 0, 0, 0, evt, spill, prev_cnt + 16'd1);
  endtask

  // Check the full output set after a step against expected values.
  task automatic checkAll(input string tag, input logic gp, input logic fe,
                          input logic pv, input logic [9:0] idx, input logic [15:0] pd,
                          input logic [13:0] evt, input logic [8:0] spill,
                          input logic [15:0] cnt);
    checkOutput({tag, ".get_package"}, 32'(get_package), 32'(gp));
    checkOutput({tag, ".frame_err"}, 32'(frame_err), 32'(fe));
    checkOutput({tag, ".payload_valid"}, 32'(payload_valid), 32'(pv));
    if (pv) begin
      checkOutput({tag, ".payload_idx"}, 32'(payload_idx), 32'(idx));
      checkOutput({tag, ".payload_data"}, 32'(payload_data), 32'(pd));
    end
    checkOutput({tag, ".pkg_evtno"}, 32'(pkg_evtno), 32'(evt));
    checkOutput({tag, ".pkg_spillno"}, 32'(pkg_spillno), 32'(spill));
    checkOutput({tag, ".pkg_count"}, 32'(pkg_count), 32'(cnt));
  endtask

  // Feed a clean package word by word (no gaps) and check only the final pulse.
  task automatic sendCleanPkg(input string tag, input logic [13:0] evt,
                              input logic [8:0] spill, input logic [15:0] cnt_after);
    applyStimulus(1, 0, 1, 16'hBCBC);
    applyStimulus(1, 0, 1, {2'b00, evt});
    applyStimulus(1, 0, 1, {7'b0, spill});
    for (int i = 0; i < PLEN; i++) applyStimulus(1, 0, 1, 16'h7000 + 16'(i));
    applyStimulus(1, 0, 1, 16'hFCFC);
    checkAll(tag, 1, 0, 0, 0, 0, evt, spill, cnt_after);
  endtask

  initial begin
    int gp_seen;
    logic [15:0] words[$];

    rstn = 1'b0; live_rising = 1'b0; data_valid = 1'b0; data_in = '0;
    @(posedge clk); #1;
    applyStimulus(0, 0, 0, 16'h0000);
    checkAll("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    // Discarded idle words, then clean package evt=1 spill=5.
    addRow(16'h1111, 0, 0, 0, 0, 0, 0, 0);
    addRow(16'hFCFC, 0, 0, 0, 0, 0, 0, 0);
    addCleanPkg(14'd1, 9'd5, 16'hA000, 0, 0, 0);
    // Bad trailer: frame_err, pkg_* unchanged.
    addRow(16'hBCBC, 0, 0, 0, 0, 1, 5, 1);
    addRow(16'h0003, 0, 0, 0, 0, 1, 5, 1);
    addRow(16'h0007, 0, 0, 0, 0, 1, 5, 1);
    for (int i = 0; i < PLEN; i++) addRow(16'hB000 + 16'(i), 0, 0, 1, 10'(i), 1, 5, 1);
    addRow(16'h1234, 0, 1, 0, 0, 1, 5, 1);
    // Event word with pad bits set, then spill word with pad bit set.
    addRow(16'hBCBC, 0, 0, 0, 0, 1, 5, 1);
    addRow(16'hC001, 0, 1, 0, 0, 1, 5, 1);
    addRow(16'hBCBC, 0, 0, 0, 0, 1, 5, 1);
    addRow(16'h0004, 0, 0, 0, 0, 1, 5, 1);
    addRow(16'h0200, 0, 1, 0, 0, 1, 5, 1);
    // Clean evt=2 spill=9 with a START marker inside the payload.
    addRow(16'hBCBC, 0, 0, 0, 0, 1, 5, 1);
    addRow(16'h0002, 0, 0, 0, 0, 1, 5, 1);
    addRow(16'h0009, 0, 0, 0, 0, 1, 5, 1);
    addRow(16'hC000, 0, 0, 1, 0, 1, 5, 1);
    addRow(16'hBCBC, 0, 0, 1, 1, 1, 5, 1);
    addRow(16'hC002, 0, 0, 1, 2, 1, 5, 1);
    addRow(16'hC003, 0, 0, 1, 3, 1, 5, 1);
    addRow(16'hFCFC, 1, 0, 0, 0, 2, 9, 2);

    applyStimulus(1, 0, 0, 16'h0000);
    foreach (vecs[k]) begin
      applyStimulus(1, 0, 1, vecs[k].data);
      checkAll($sformatf("vec%0d", k), vecs[k].exp_gp, vecs[k].exp_fe, vecs[k].exp_pv,
               vecs[k].exp_idx, vecs[k].data, vecs[k].exp_evt, vecs[k].exp_spill,
               vecs[k].exp_cnt);
    end

    // Same package evt=1 spill=5 with random gaps shorter than the timeout.
    words = '{16'hBCBC, 16'h0001, 16'h0005, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hFCFC};
    gp_seen = 0;
    foreach (words[w]) begin
      int gap = $urandom_range(TMO - 1, 0);
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1, 0, 0, 16'hDEAD);
        if (get_package) gp_seen++;
        checkOutput("gaps.idle_no_err", 32'(frame_err), 0);
      end
      applyStimulus(1, 0, 1, words[w]);
      if (get_package) gp_seen++;
      if (w >= 3 && w < 3 + PLEN) begin
        checkOutput("gaps.payload_valid", 32'(payload_valid), 1);
        checkOutput("gaps.payload_idx", 32'(payload_idx), 32'(w - 3));
        checkOutput("gaps.payload_data", 32'(payload_data), 32'(words[w]));
      end
    end
    checkOutput("gaps.get_package_once", 32'(gp_seen), 1);
    checkAll("gaps.end", 1, 0, 0, 0, 0, 1, 5, 3);

    // Timeout mid-payload: frame_err exactly at the TMO-th idle cycle.
    applyStimulus(1, 0, 1, 16'hBCBC);
    applyStimulus(1, 0, 1, 16'h0006);
    applyStimulus(1, 0, 1, 16'h0008);
    applyStimulus(1, 0, 1, 16'hD000);
    for (int g = 1; g <= TMO; g++) begin
      applyStimulus(1, 0, 0, 16'h0000);
      checkOutput($sformatf("tmo.idle%0d", g), 32'(frame_err), 32'(g == TMO));
    end
    applyStimulus(1, 0, 1, 16'hD001);
    applyStimulus(1, 0, 1, 16'hD002);
    applyStimulus(1, 0, 1, 16'hD003);
    applyStimulus(1, 0, 1, 16'hFCFC);
    checkAll("tmo.discard", 0, 0, 0, 0, 0, 1, 5, 3);

    // live_rising mid-payload: abort, pkg_count cleared, pkg_* kept.
    applyStimulus(1, 0, 1, 16'hBCBC);
    applyStimulus(1, 0, 1, 16'h000A);
    applyStimulus(1, 0, 1, 16'h000B);
    applyStimulus(1, 0, 1, 16'hE000);
    applyStimulus(1, 1, 1, 16'hE001);
    checkAll("live.abort", 0, 0, 0, 0, 0, 1, 5, 0);
    applyStimulus(1, 0, 1, 16'hE002);
    applyStimulus(1, 0, 1, 16'hE003);
    applyStimulus(1, 0, 1, 16'hFCFC);
    checkAll("live.discard", 0, 0, 0, 0, 0, 1, 5, 0);
    sendCleanPkg("live.next", 14'h3FFF, 9'h1FF, 1);

    // Reset mid-package, with live_rising also high to show reset priority.
    applyStimulus(1, 0, 1, 16'hBCBC);
    applyStimulus(1, 0, 1, 16'h0011);
    applyStimulus(1, 0, 1, 16'h0012);
    applyStimulus(1, 0, 1, 16'hF000);
    applyStimulus(0, 1, 1, 16'hF001);
    checkAll("rst.mid", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 16'hF002);
    applyStimulus(1, 0, 1, 16'hF003);
    applyStimulus(1, 0, 1, 16'hFCFC);
    checkAll("rst.discard", 0, 0, 0, 0, 0, 0, 0, 0);
    sendCleanPkg("rst.next", 14'd4, 9'd2, 1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
